// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor.
// Holds the FSM state encoding, default timing parameters and a
// width helper used to size counters from cycle-count parameters.
`timescale 1ns/1ps
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous level inputs.
// Ports: clk (destination clock), rst (sync active-high, clears both
// flops to 0), d (async input), q (synchronised output).
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the pixel-clock PLL, running on refclk.
// Pulses the PLL reset, waits for lock, requires lock to stay stable
// before releasing sys_rst, re-arms on lock loss and latches a fault
// after too many consecutive failed attempts.
// Ports: refclk/rst (clock, sync active-high reset), locked (async PLL
// lock), clear_fault (pulse, honoured only in FAULT), pll_rst/sys_rst
// (active-high resets out), ready (RUN), fault (FAULT), retry_count
// (consecutive failures), lock_loss_cnt (saturating RUN lock losses).
`timescale 1ns/1ps
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic                                     refclk,
  input  logic                                     rst,
  input  logic                                     locked,
  input  logic                                     clear_fault,
  output logic                                     pll_rst,
  output logic                                     sys_rst,
  output logic                                     ready,
  output logic                                     fault,
  output logic [width_for(MAX_RETRIES+1)-1:0]      retry_count,
  output logic [7:0]                               lock_loss_cnt
);

  localparam int unsigned CNT_W = width_for(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam int unsigned RC_W  = width_for(MAX_RETRIES + 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RC_W-1:0]   retry_nxt;
  logic [7:0]        loss_nxt;
  logic              take_retry;
  logic              locked_s;
  logic              pll_rst_nxt, sys_rst_nxt, ready_nxt, fault_nxt;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state, counter and output decode; outputs follow the next state.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    retry_nxt  = retry_count;
    loss_nxt   = lock_loss_cnt;
    take_retry = 1'b0;

    case (state)
      PLL_RESET: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) state_nxt = STABILIZE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) take_retry = 1'b1;
      end
      STABILIZE: begin
        // Any drop of lock while settling is a failed attempt.
        if (!locked_s) take_retry = 1'b1;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        cnt_nxt = cnt;
        if (!locked_s) begin
          if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
          take_retry = 1'b1;
        end
      end
      FAULT: begin
        cnt_nxt = cnt;
        if (clear_fault) begin
          state_nxt = PLL_RESET;
          retry_nxt = '0;
        end
      end
      default: state_nxt = PLL_RESET;
    endcase

    if (take_retry) begin
      if (retry_count == RC_W'(MAX_RETRIES)) begin
        state_nxt = FAULT;
      end else begin
        retry_nxt = retry_count + RC_W'(1);
        state_nxt = PLL_RESET;
      end
    end

    // Shared counter restarts on every state change.
    if (state_nxt != state) cnt_nxt = '0;

    pll_rst_nxt = (state_nxt == PLL_RESET) || (state_nxt == FAULT);
    sys_rst_nxt = (state_nxt != RUN);
    ready_nxt   = (state_nxt == RUN);
    fault_nxt   = (state_nxt == FAULT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= PLL_RESET;
      cnt           <= '0;
      retry_count   <= '0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_count   <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      pll_rst       <= pll_rst_nxt;
      sys_rst       <= sys_rst_nxt;
      ready         <= ready_nxt;
      fault         <= fault_nxt;
    end
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the 40 MHz pixel-clock PLL. It runs on the 50 MHz reference clock and drives the PLL reset input. It watches the PLL `locked` output and releases a system reset only after lock has been stable for a set time. On lock loss it re-arms the PLL, and after repeated failures it latches a fault. Downstream pixel-domain logic re-synchronises `sys_rst` into `outclk_0`; that synchroniser is outside this block.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: PLL reset pulse width, in refclk cycles (≥2).
- `LOCK_TIMEOUT`, default 50000: maximum cycles to wait for lock (1 ms), ≥2.
- `STABLE_CYCLES`, default 1024: cycles of continuous lock required before release, ≥2.
- `MAX_RETRIES`, default 3: failed attempts tolerated before FAULT.

Ports (one clock; reset is synchronous and active-high):
- `refclk` in 1: 50 MHz clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock. Asynchronous to `refclk`.
- `clear_fault` in 1: single-cycle pulse. Leaves FAULT only.
- `pll_rst` out 1: reset to the PLL, active-high.
- `sys_rst` out 1: system reset, active-high.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retry_count` out $clog2(MAX_RETRIES+1): consecutive failed attempts.
- `lock_loss_cnt` out 8: lock losses from RUN. Saturates at 255.

## Operation
- `locked` passes through a 2-flop synchroniser to give `locked_s`. The FSM uses only `locked_s`.
- One shared cycle counter `cnt` serves all states. It is cleared on every state change.
- **PLL_RESET**: `pll_rst`=1, `sys_rst`=1.
  - When `cnt`=PLL_RST_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=1, go to STABILIZE.
  - Else, if `cnt`=LOCK_TIMEOUT-1, take the *retry* path.
- **STABILIZE**: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=0, take the *retry* path. A glitch counts as a failure.
  - Else, if `cnt`=STABLE_CYCLES-1, go to RUN and clear `retry_count`.
- **RUN**: `sys_rst`=0, `ready`=1.
  - If `locked_s`=0, increment `lock_loss_cnt` (saturating) and take the *retry* path.
- ***Retry* path**:
  - If `retry_count`=MAX_RETRIES, go to FAULT.
  - Otherwise increment `retry_count` and go to PLL_RESET.
- **FAULT**: `pll_rst`=1, `sys_rst`=1, `fault`=1.
  - `retry_count` holds at MAX_RETRIES.
  - On `clear_fault`, clear `retry_count` and go to PLL_RESET.
  - `lock_loss_cnt` is not cleared by `clear_fault`.
- `clear_fault` is ignored in all states other than FAULT.
- `rst` has priority over everything. Its effect is the same at any point, including mid-sequence.

## Timing
- All outputs are registered. They are decoded from the next state, so they change on the same edge as the state register.
- Reset values while `rst`=1:
  - state PLL_RESET, `cnt`=0, sync flops 0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0.
  - `retry_count`=0, `lock_loss_cnt`=0.
- After `rst` falls, `pll_rst` stays high for exactly PLL_RST_CYCLES cycles.
- Lock-detect latency: a `locked` rise sampled at edge e causes the FSM transition at edge e+2.
- Lock-to-release: `sys_rst` falls exactly STABLE_CYCLES cycles after STABILIZE is entered.
- Lock-loss response: a `locked` fall sampled at edge e gives `sys_rst`=1 and `pll_rst`=1 at edge e+2.
- Timeout and stability checks on the same cycle: the `locked_s` check has priority over the counter terminal count.
- `cnt` width is $clog2 of the largest of the three cycle parameters. `cnt` never wraps, because every state leaves at or before its terminal count.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum: PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT;
  - the default parameter constants;
  - a `clog2`-based width helper.
- One sub-module, `sync_2ff`: a 1-bit, two-flop synchroniser with reset value 0. It is reused elsewhere for other async inputs.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Nominal bring-up.** Release `rst`; raise `locked` 6 cycles after `pll_rst` falls. Expect `pll_rst` high for exactly 4 cycles, then `sys_rst` falls and `ready` rises 2+1+8 cycles after the `locked` edge, with `retry_count`=0.
- **Lock timeout.** Hold `locked`=0. Expect WAIT_LOCK to last exactly 20 cycles, then 4-cycle `pll_rst` pulses, with `retry_count` going 1, then 2. The third timeout enters FAULT with `fault`=1, `pll_rst`=1 and `retry_count`=2.
- **Glitch during STABILIZE.** Drop `locked` for 1 cycle at stabilize cycle 5. Expect a return to PLL_RESET, `retry_count`=1, `sys_rst` never low. A clean second attempt reaches RUN with `retry_count` cleared to 0.
- **Lock loss in RUN.** Drop `locked` while in RUN. Expect `sys_rst`=1 and `pll_rst`=1 two edges later and `lock_loss_cnt`=1. Repeat 300 times: `lock_loss_cnt` saturates at 255.
- **Fault clear and mid-sequence reset.** Pulse `clear_fault` in RUN: no effect. Pulse it in FAULT: expect PLL_RESET and `retry_count`=0, with `lock_loss_cnt` preserved. Assert `rst` mid-STABILIZE: expect all reset values on the next edge.
